// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the byte-enable / alignment / legality helpers used at request decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Store byte enables; loads always read the whole word.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords need addr[0] clear, words need addr[1:0] clear.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Right-aligns the addressed byte/halfword of a memory word and extends it
// according to the load funct3.
import lsu_pkg::*;

module load_align (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Lane select followed by sign/zero extension.
  always_comb begin
    shifted_s = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result = word;
      F3_BU:   result = {24'h000000, shifted_s[7:0]};
      F3_HU:   result = {16'h0000, shifted_s[15:0]};
      default: result = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: IDLE accepts and decodes a request,
// ACCESS drives the memory strobes until ack or timeout, RESP pulses the result.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        memR,
  output logic        memW,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  lsu_state_t  state_r, state_n;
  logic        ready_r;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic [7:0]  cnt_r;
  logic        err_r;
  logic        accept_s;
  logic        bad_req_s;
  logic        timeout_s;
  logic [31:0] aligned_s;

  // ready_r gates acceptance, so the cycle right after reset cannot take a request.
  assign accept_s  = req_valid & ready_r;
  assign bad_req_s = f3_illegal(req_we, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
  assign timeout_s = (cnt_r == TO_LAST);

  // Next-state decode; an ack takes priority over a simultaneous timeout.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n = bad_req_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || timeout_s) begin
          state_n = ST_RESP;
        end else begin
          state_n = ST_ACCESS;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, request capture, ack data capture and the timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= 32'h00000000;
      wdata_r <= 32'h00000000;
      rdata_r <= 32'h00000000;
      cnt_r   <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      ready_r <= (state_n == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r    <= req_we;
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            err_r   <= bad_req_s;
            cnt_r   <= 8'd0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            rdata_r <= mem_rdata;
            err_r   <= 1'b0;
          end else if (timeout_s) begin
            err_r   <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  load_align u_load_align (
    .word    (rdata_r),
    .addr_lo (addr_r[1:0]),
    .funct3  (f3_r),
    .result  (aligned_s)
  );

  // Store data is replicated across the lanes the byte enables select from.
  always_comb begin
    case (f3_r)
      F3_B:    mem_wdata = {4{wdata_r[7:0]}};
      F3_H:    mem_wdata = {2{wdata_r[15:0]}};
      default: mem_wdata = wdata_r;
    endcase
  end

  // Strobes and response outputs decode from state so reset clears them at once.
  assign req_ready  = ready_r;
  assign memR       = (state_r == ST_ACCESS) & ~we_r;
  assign memW       = (state_r == ST_ACCESS) &  we_r;
  assign mem_addr   = {addr_r[31:2], 2'b00};
  assign mem_be     = (state_r != ST_ACCESS) ? 4'b0000 :
                      (we_r ? be_gen(f3_r, addr_r[1:0]) : 4'b1111);
  assign resp_valid = (state_r == ST_RESP);
  assign resp_err   = resp_valid & err_r;
  assign resp_rdata = (resp_valid & ~err_r & ~we_r) ? aligned_s : 32'h00000000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        memR, memW, mem_ack;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .memR(memR), .memW(memW), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: push expectation, drive, ack after ack_k cycles of ACCESS
  // (ack_k < 0 means never), check strobes each cycle and the response timing.
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_k, input logic [31:0] rword, input int exp_lat,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic exp_err, input logic [31:0] exp_rd);
    int   cyc;
    int   strobes;
    bit   done;
    exp_t e;
    sb_q.push_back('{err: exp_err, rd: exp_rd});
    @(negedge clk);
    check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    cyc = 0; strobes = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      mem_rdata = rword;
      mem_ack   = (ack_k >= 0 && cyc == 1 + ack_k) ? 1'b1 : 1'b0;
      if (memR || memW) begin
        strobes++;
        check({name, ".memW"}, {31'd0, memW}, {31'd0, we});
        check({name, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check({name, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (we) check({name, ".wdata"}, mem_wdata, exp_wd);
      end
      if (resp_valid) begin
        done = 1'b1;
        check({name, ".lat"}, cyc, exp_lat);
        check({name, ".strobes"}, strobes, exp_lat - 1);
        if (sb_q.size() == 0) begin
          check({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({name, ".err"}, {31'd0, resp_err}, {31'd0, e.err});
          check({name, ".rdata"}, resp_rdata, e.rd);
        end
      end
    end
    mem_ack = 1'b0;
    if (!done) check({name, ".timeout_wait"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.ready", {31'd0, req_ready}, 32'd0);
    check("rst.memR", {31'd0, memR}, 32'd0);
    check("rst.memW", {31'd0, memW}, 32'd0);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.mem_be", {28'd0, mem_be}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    #1 check("rel.ready_low", {31'd0, req_ready}, 32'd0);

    //        name    we    f3      addr          wdata         k   rword         lat be       wd            err   rd
    run_txn("sw",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,        2, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
    run_txn("lb",   1'b0, 3'b000, 32'h103, 32'h0,        0, 32'h80FF1234, 2, 4'b1111, 32'h0,        1'b0, 32'hFFFFFF80);
    run_txn("lbu",  1'b0, 3'b100, 32'h103, 32'h0,        2, 32'h80FF1234, 4, 4'b1111, 32'h0,        1'b0, 32'h00000080);
    run_txn("sh",   1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 32'h0,        3, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0);
    run_txn("lwmis",1'b0, 3'b010, 32'h102, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0);
    run_txn("ld011",1'b0, 3'b011, 32'h100, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0);
    run_txn("lh",   1'b0, 3'b001, 32'h102, 32'h0,        0, 32'h80FF1234, 2, 4'b1111, 32'h0,        1'b0, 32'hFFFF80FF);
    run_txn("lhu",  1'b0, 3'b101, 32'h100, 32'h0,        0, 32'h80FF1234, 2, 4'b1111, 32'h0,        1'b0, 32'h00001234);
    run_txn("sb",   1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 32'h0,        2, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0);
    run_txn("st100",1'b1, 3'b100, 32'h100, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0);
    run_txn("shmis",1'b1, 3'b001, 32'h101, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0);
    run_txn("tmo",  1'b0, 3'b010, 32'h040, 32'h0,       -1, 32'h0,        5, 4'b1111, 32'h0,        1'b1, 32'h0);
    run_txn("ack4", 1'b0, 3'b010, 32'h040, 32'h0,        3, 32'hCAFEF00D, 5, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D);

    // Reset two cycles into a stalled LW
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rma.memR_c1", {31'd0, memR}, 32'd1);
    @(negedge clk);
    check("rma.memR_c2", {31'd0, memR}, 32'd1);
    rst = 1'b1;
    #1;
    check("rma.memR_drop", {31'd0, memR}, 32'd0);
    check("rma.memW_drop", {31'd0, memW}, 32'd0);
    check("rma.resp_in_rst", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rma.ready_rel", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("rma.ready_after", {31'd0, req_ready}, 32'd1);
      check("rma.no_resp", {31'd0, resp_valid}, 32'd0);
    end

    run_txn("lwpost", 1'b0, 3'b010, 32'h080, 32'h0, 0, 32'h11223344, 2, 4'b1111, 32'h0, 1'b0, 32'h11223344);

    check("sb.drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
